// File: rtl/lcd_frame_capture.sv
// Packs 2-bit PPU shade pixels four per byte into a double-banked framebuffer
// and publishes completed frames to a consumer via frame_ready/frame_ack.
// Latency: fb_we one cycle after the 4th pixel of a group. No backpressure:
// pixels accepted every cycle; frames are dropped when the consumer lags.
// Ports:
//   clk, reset (async active-low)      clock / reset
//   frame_start, pix_valid, pix_data   PPU pixel stream in
//   fb_we, fb_addr, fb_wdata           framebuffer byte write port
//   frame_ready, ready_bank, frame_ack publish handshake with the consumer
//   drop_count, capturing              status
module lcd_frame_capture #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [1:0]        pix_data,
  output logic              fb_we,
  output logic [13:0]       fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              frame_ready,
  output logic              ready_bank,
  input  logic              frame_ack,
  output logic [DROP_W-1:0] drop_count,
  output logic              capturing
);

  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int PIX_W  = $clog2(NPIX);
  localparam int BYTE_W = 13;

  typedef enum logic [1:0] {SYNC, CAPTURE, PUBLISH} state_t;

  state_t            state, state_nxt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [BYTE_W-1:0] byte_idx;
  logic [5:0]        pack;      // first three pixels of the current group
  logic              cap_bank;

  logic take_pix, last_pix, short_frame, bank_free, drop_event, clear_cnt;

  always_comb begin
    short_frame = (state == CAPTURE) && frame_start;
    // frame_start wins over a coincident pixel: the pixel belongs to no frame
    take_pix    = (state == CAPTURE) && pix_valid && !frame_start;
    last_pix    = take_pix && (pix_cnt == PIX_W'(NPIX - 1));
    clear_cnt   = frame_start;
    // An ack landing in the PUBLISH cycle frees the bank for the new frame
    bank_free   = !frame_ready || frame_ack;
    drop_event  = short_frame || ((state == PUBLISH) && !bank_free);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (frame_start) state_nxt = CAPTURE;
      CAPTURE: if (last_pix)    state_nxt = PUBLISH;
      PUBLISH: state_nxt = frame_start ? CAPTURE : SYNC;
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_nxt;
  end

  assign capturing = (state == CAPTURE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= '0;
      frame_ready <= 1'b0;
      ready_bank  <= 1'b0;
      drop_count  <= '0;
      cap_bank    <= 1'b0;
      pix_cnt     <= '0;
      byte_idx    <= '0;
      pack        <= '0;
    end else begin
      fb_we <= 1'b0;

      if (frame_ready && frame_ack)
        frame_ready <= 1'b0;

      // Any pending partial group is simply abandoned here
      if (clear_cnt) begin
        pix_cnt  <= '0;
        byte_idx <= '0;
      end else if (take_pix) begin
        pack    <= {pack[3:0], pix_data};
        pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        if (pix_cnt[1:0] == 2'b11) begin
          fb_we    <= 1'b1;
          fb_addr  <= {cap_bank, byte_idx};
          fb_wdata <= {pack, pix_data};
          byte_idx <= last_pix ? '0 : byte_idx + 1'b1;
        end
      end

      if (drop_event && (drop_count != {DROP_W{1'b1}}))
        drop_count <= drop_count + 1'b1;

      // The final byte's address was registered last cycle, so flipping
      // cap_bank here cannot redirect it.
      if ((state == PUBLISH) && bank_free) begin
        frame_ready <= 1'b1;
        ready_bank  <= cap_bank;
        cap_bank    <= ~cap_bank;
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_capture.sv
module tb_lcd_frame_capture;

  localparam int NPIX = 160 * 144;

  logic       clk = 1'b0;
  logic       reset, frame_start, pix_valid, frame_ack;
  logic [1:0] pix_data;
  logic       fb_we, frame_ready, ready_bank, capturing;
  logic [13:0] fb_addr;
  logic [7:0] fb_wdata, drop_count;

  lcd_frame_capture dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .frame_ready(frame_ready), .ready_bank(ready_bank), .frame_ack(frame_ack),
    .drop_count(drop_count), .capturing(capturing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t  sbq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic sb_bank;
  int   sb_idx;
  int   gcnt;
  logic [7:0] grp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Write monitor: every fb_we pulse must match the oldest expected byte and
  // appear exactly one cycle after its 4th pixel was presented.
  always @(negedge clk) begin
    if (fb_we) begin
      if (sbq.size() == 0) begin
        check("wr_unexpected", {18'd0, fb_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        check("wr_addr", {18'd0, fb_addr}, {18'd0, e.a});
        check("wr_data", {24'd0, fb_wdata}, {24'd0, e.d});
        check("wr_latency", cyc, e.c + 1);
      end
    end
  end

  task automatic tick(input logic v, input logic [1:0] p);
    @(negedge clk);
    frame_start = 1'b0;
    frame_ack   = 1'b0;
    pix_valid   = v;
    pix_data    = p;
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    frame_ack   = 1'b0;
    pix_valid   = 1'b0;
    sb_idx      = 0;
    gcnt        = 0;
  endtask

  // rnd: random shades instead of 0,1,2,3; gap: first 600 pixels 1-in-3 cycles;
  // ack_end: raise frame_ack in the cycle after the last pixel (the PUBLISH cycle)
  task automatic send(input int n, input bit rnd, input bit gap, input bit ack_end,
                      input bit expect_wr);
    logic [1:0] p;
    for (int i = 0; i < n; i++) begin
      if (gap && i < 600) begin
        tick(1'b0, 2'd0);
        tick(1'b0, 2'd0);
      end
      p = rnd ? 2'($urandom_range(3)) : 2'(i % 4);
      tick(1'b1, p);
      if (expect_wr) begin
        grp = {grp[5:0], p};
        gcnt++;
        if (gcnt == 4) begin
          sbq.push_back('{a: {sb_bank, 13'(sb_idx)}, d: grp, c: cyc});
          sb_idx++;
          gcnt = 0;
        end
      end
    end
    tick(1'b0, 2'd0);
    frame_ack = ack_end;
  endtask

  initial begin
    reset = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 2'd0; frame_ack = 1'b0;
    sb_bank = 1'b0; sb_idx = 0; gcnt = 0; grp = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_fb_we", {31'd0, fb_we}, 0);
    check("rst_fb_addr", {18'd0, fb_addr}, 0);
    check("rst_frame_ready", {31'd0, frame_ready}, 0);
    check("rst_ready_bank", {31'd0, ready_bank}, 0);
    check("rst_drop_count", {24'd0, drop_count}, 0);
    check("rst_capturing", {31'd0, capturing}, 0);
    reset = 1'b1;

    // Frame A: dense 0,1,2,3 -> 5760 bytes of 1B into bank 0, published
    start_frame();
    send(NPIX, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 2'd0);
    check("a_frame_ready", {31'd0, frame_ready}, 1);
    check("a_ready_bank", {31'd0, ready_bank}, 0);
    check("a_drop_count", {24'd0, drop_count}, 0);
    check("a_capturing", {31'd0, capturing}, 0);
    sb_bank = 1'b1;

    // Frame B: gapped start, no ack -> written to bank 1, then dropped
    start_frame();
    send(NPIX, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 2'd0);
    check("b_frame_ready", {31'd0, frame_ready}, 1);
    check("b_ready_bank", {31'd0, ready_bank}, 0);
    check("b_drop_count", {24'd0, drop_count}, 1);

    // Frame C: random shades, ack in the PUBLISH cycle -> bank 1 published
    start_frame();
    send(NPIX, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 2'd0);
    check("c_frame_ready", {31'd0, frame_ready}, 1);
    check("c_ready_bank", {31'd0, ready_bank}, 1);
    check("c_drop_count", {24'd0, drop_count}, 1);
    sb_bank = 1'b0;

    // Short frame: 1002 pixels (pending half group), restart at byte 0 bank 0
    start_frame();
    send(1002, 1'b0, 1'b0, 1'b0, 1'b1);
    start_frame();
    send(8, 1'b0, 1'b0, 1'b0, 1'b1);
    check("short_drop_count", {24'd0, drop_count}, 2);
    check("short_capturing", {31'd0, capturing}, 1);

    // Reset mid-frame: outputs clear without a clock edge
    send(3000, 1'b1, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_fb_we", {31'd0, fb_we}, 0);
    check("mid_rst_fb_addr", {18'd0, fb_addr}, 0);
    check("mid_rst_frame_ready", {31'd0, frame_ready}, 0);
    check("mid_rst_ready_bank", {31'd0, ready_bank}, 0);
    check("mid_rst_drop_count", {24'd0, drop_count}, 0);
    check("mid_rst_capturing", {31'd0, capturing}, 0);
    check("mid_rst_sb_drained", sbq.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Pixels without frame_start must not produce writes
    send(40, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 2'd0);
    check("sync_capturing", {31'd0, capturing}, 0);

    // 300 short frames: counter saturates at 255 instead of wrapping
    start_frame();
    for (int i = 0; i < 300; i++) start_frame();
    tick(1'b0, 2'd0);
    check("sat_drop_count", {24'd0, drop_count}, 255);
    check("sat_capturing", {31'd0, capturing}, 1);
    repeat (3) tick(1'b0, 2'd0);
    check("end_sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
